// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder slice.
package rv32_fetch_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam logic [31:0] RV_NOP         = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        ERR
    } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Cycle counter for outstanding memory reads; flags when the limit is reached.
module fetch_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the LIMIT-th waiting cycle so the error lands after exactly LIMIT cycles.
    assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_responder.sv
// PC-fetch responder: one outstanding instruction-memory read, result held for decode.
// Optional read timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_responder
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_addr,
    input  logic              fetch_en,
    input  logic              flush,
    output logic              pc_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         wd_expired;

`ifdef FETCH_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;

    assign wd_en  = (state_q == WAIT) || (state_q == DRAIN);
    assign wd_clr = ((state_d == WAIT) || (state_d == DRAIN)) && (state_d != state_q);

    fetch_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (fetch_en && !flush) begin
                    req_pc_d = pc_addr;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // A grant in the flush cycle still owes a response, so it must be drained.
                if (flush) begin
                    state_d = mem_gnt ? DRAIN : IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        instr_d    = mem_rdata;
                        instr_pc_d = req_pc_q;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == ERR && state_q != ERR) begin
            err_d      = 1'b1;
            instr_d    = '0;
            instr_pc_d = '0;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_pc_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = mem_req ? req_pc_q[ADDR_W-1:0] : '0;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign pc_ready    = rst && (state_q != ERR)
                         && (flush || ((state_q == HOLD) && instr_ready));

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder; timeout cases run when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        fetch_en;
    logic        flush;
    logic        pc_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int unsigned gnt_dly;
        int unsigned rv_dly;
        int unsigned rdy_dly;
        logic [15:0] exp_addr;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    instr_fetch_responder #(
        .ADDR_W         (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .pc_ready    (pc_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got no entry expected one (t=%0t)", $time);
        end else begin
            n_checks--;
            e = sb_q.pop_front();
            check("sb_instr", instr, e.instr);
            check("sb_instr_pc", instr_pc, e.pc);
        end
    endtask

    // Enters with the DUT in IDLE just after a clock edge; leaves it in IDLE the same way.
    task automatic do_fetch(input vec_t v);
        pc_addr  = v.pc;
        fetch_en = 1'b1;
        #1;
        check("idle_mem_req", mem_req, 1'b0);
        check("idle_pc_ready", pc_ready, 1'b0);
        step();
        fetch_en = 1'b0;
        pc_addr  = 32'hFFFF_FFF0;
        for (int unsigned i = 0; i < v.gnt_dly; i++) begin
            #1;
            check("req_stall_mem_req", mem_req, 1'b1);
            check("req_stall_mem_addr", mem_addr, v.exp_addr);
            step();
        end
        mem_gnt = 1'b1;
        #1;
        check("req_mem_req", mem_req, 1'b1);
        check("req_mem_addr", mem_addr, v.exp_addr);
        step();
        mem_gnt = 1'b0;
        for (int unsigned i = 0; i < v.rv_dly; i++) begin
            #1;
            check("wait_valid", instr_valid, 1'b0);
            check("wait_mem_req", mem_req, 1'b0);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        sb_q.push_back('{instr: v.rdata, pc: v.pc});
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        for (int unsigned i = 0; i < v.rdy_dly; i++) begin
            #1;
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr_stable", instr, v.rdata);
            check("hold_pc_ready", pc_ready, 1'b0);
            step();
        end
        instr_ready = 1'b1;
        #1;
        check("hold_valid_final", instr_valid, 1'b1);
        check("hold_pc_ready_final", pc_ready, 1'b1);
        pop_check();
        step();
        instr_ready = 1'b0;
        #1;
        check("post_valid", instr_valid, 1'b0);
        check("post_pc_ready", pc_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vecs[0] = '{pc: 32'h0000_0010, rdata: 32'h0050_0093, gnt_dly: 0, rv_dly: 0, rdy_dly: 0, exp_addr: 16'h0010};
        vecs[1] = '{pc: 32'h0000_0020, rdata: 32'hAABB_CCDD, gnt_dly: 4, rv_dly: 0, rdy_dly: 5, exp_addr: 16'h0020};
        vecs[2] = '{pc: 32'hABCD_1234, rdata: 32'h0000_0013, gnt_dly: 1, rv_dly: 2, rdy_dly: 1, exp_addr: 16'h1234};
        vecs[3] = '{pc: 32'h0000_FFFF, rdata: 32'hFFFF_FFFF, gnt_dly: 0, rv_dly: 3, rdy_dly: 0, exp_addr: 16'hFFFF};
        vecs[4] = '{pc: 32'h0000_0080, rdata: 32'h0010_0113, gnt_dly: 0, rv_dly: 0, rdy_dly: 2, exp_addr: 16'h0080};

        // Reset with hostile inputs: everything must read zero, pc_ready included.
        rst         = 1'b0;
        pc_addr     = 32'h0000_0010;
        fetch_en    = 1'b1;
        flush       = 1'b1;
        mem_gnt     = 1'b1;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        instr_ready = 1'b1;
        repeat (3) step();
        check("rst_pc_ready", pc_ready, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_fetch_err", fetch_err, 1'b0);

        fetch_en    = 1'b0;
        flush       = 1'b0;
        mem_gnt     = 1'b0;
        instr_ready = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_mem_req", mem_req, 1'b0);
            check("post_rst_rvalid_ignored", instr_valid, 1'b0);
        end
        mem_rvalid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_fetch(vecs[i]);
        end

        // Flush while waiting for data: response drained, never exposed.
        pc_addr  = 32'h0000_0040;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        pc_addr = 32'h0000_0080;
        #1;
        check("wflush_pc_ready", pc_ready, 1'b1);
        step();
        flush    = 1'b0;
        fetch_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("drain_mem_req", mem_req, 1'b0);
            check("drain_pc_ready", pc_ready, 1'b0);
            step();
        end
        fetch_en   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        #1;
        check("drain_valid", instr_valid, 1'b0);
        check("drain_mem_req_after", mem_req, 1'b0);
        n_checks++;
        if (instr === 32'h1234_5678) begin
            n_fail++;
            $display("FAIL drain_data_leak: got %h expected old instr", instr);
        end
        do_fetch(vecs[4]);

        // Flush in REQ before any grant: request withdrawn, no drain needed.
        pc_addr  = 32'h0000_0050;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        flush    = 1'b1;
        #1;
        check("rflush_pc_ready", pc_ready, 1'b1);
        step();
        flush = 1'b0;
        #1;
        check("rflush_mem_req", mem_req, 1'b0);
        check("rflush_mem_addr", mem_addr, 16'h0000);

        // Flush and instr_ready together in HOLD.
        pc_addr  = 32'h0000_0060;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00A0_0113;
        sb_q.push_back('{instr: 32'h00A0_0113, pc: 32'h0000_0060});
        step();
        mem_rvalid = 1'b0;
        #1;
        check("hflush_valid_pre", instr_valid, 1'b1);
        flush       = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("hflush_pc_ready", pc_ready, 1'b1);
        pop_check();
        step();
        flush       = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("hflush_valid_post", instr_valid, 1'b0);
        check("hflush_mem_req", mem_req, 1'b0);
        do_fetch(vecs[0]);

        check("sb_drained", sb_q.size(), 0);

`ifdef FETCH_TIMEOUT_EN
        pc_addr  = 32'h0000_0070;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_err_early", fetch_err, 1'b0);
            step();
        end
        check("to_err_set", fetch_err, 1'b1);
        flush      = 1'b1;
        fetch_en   = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        check("to_pc_ready", pc_ready, 1'b0);
        check("to_mem_req", mem_req, 1'b0);
        check("to_valid", instr_valid, 1'b0);
        step();
        check("to_err_sticky", fetch_err, 1'b1);
        check("to_mem_req_stuck", mem_req, 1'b0);
        flush      = 1'b0;
        fetch_en   = 1'b0;
        mem_rvalid = 1'b0;
        rst        = 1'b0;
        #1;
        check("to_err_cleared", fetch_err, 1'b0);
        step();
        rst = 1'b1;
        do_fetch(vecs[4]);
`else
        check("no_timeout_err", fetch_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
